elastic_pipe: RTL and testbench

- Parameterised pipeline of DEPTH register stages with a valid/ready handshake on both ends.
- Successor to the fixed-delay valid-only pipe. Adds downstream backpressure, bubble collapsing, a synchronous flush and an occupancy count.
- Sits between streaming producers and consumers; Driver/Monitor benches attach to the din and dout interfaces.

---
 rtl/elastic_pipe.sv | 82 ++++++++
 tb/tb_elastic_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_pipe.sv
// Elastic register pipeline: DEPTH stages with valid/ready on both ends.
// Empty stages fill during a stall, a synchronous flush drops all beats, and occupancy tracks valid stages.
module elastic_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic [WIDTH-1:0] din,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] occupancy
);

  // Handshake: a beat moves on an edge where valid and ready are both high.
  // Valid never depends on ready, and a stalled stage holds its valid and data unchanged.
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] data [DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] occ_q;

  // A stage can load whenever it is empty or its successor is draining it.
  always_comb begin
    rdy = '0;
    rdy[DEPTH-1] = !vld[DEPTH-1] | dout_rdy;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      rdy[k] = !vld[k] | rdy[k+1];
    end
  end

  assign din_rdy   = rdy[0] & !flush;
  assign in_fire   = din_vld & din_rdy;
  assign out_fire  = vld[DEPTH-1] & dout_rdy;
  assign dout_vld  = vld[DEPTH-1];
  assign dout      = data[DEPTH-1];
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data[k] <= '0;
      end
    end else if (flush) begin
      vld <= '0;
    end else begin
      if (in_fire) begin
        vld[0]  <= 1'b1;
        data[0] <= din;
      end else if (rdy[0]) begin
        vld[0] <= 1'b0;
      end
      // Data of an empty upstream stage is not copied, so idle stages keep stale data.
      for (int k = 1; k < DEPTH; k++) begin
        if (rdy[k]) begin
          vld[k] <= vld[k-1];
          if (vld[k-1]) begin
            data[k] <= data[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: DEPTH=4/WIDTH=32 and DEPTH=1/WIDTH=8 instances behind one driver,
// a negedge monitor popping an expected queue, and directed occupancy/latency checks.
module tb_elastic_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic        rst_n, flush, din_vld, dout_rdy, sel;
  logic [31:0] din;

  logic        a_din_vld, a_din_rdy, a_dout_vld, a_dout_rdy;
  logic [31:0] a_dout;
  logic [2:0]  a_occ;
  logic        b_din_vld, b_din_rdy, b_dout_vld, b_dout_rdy;
  logic [7:0]  b_dout;
  logic [0:0]  b_occ;

  assign a_din_vld  = din_vld & !sel;
  assign b_din_vld  = din_vld & sel;
  assign a_dout_rdy = dout_rdy & !sel;
  assign b_dout_rdy = dout_rdy & sel;

  elastic_pipe #(.WIDTH(32), .DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .din_vld(a_din_vld), .din_rdy(a_din_rdy), .din(din),
    .dout_vld(a_dout_vld), .dout_rdy(a_dout_rdy), .dout(a_dout),
    .occupancy(a_occ)
  );

  elastic_pipe #(.WIDTH(8), .DEPTH(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .din_vld(b_din_vld), .din_rdy(b_din_rdy), .din(din[7:0]),
    .dout_vld(b_dout_vld), .dout_rdy(b_dout_rdy), .dout(b_dout),
    .occupancy(b_occ)
  );

  logic        din_rdy_s, dout_vld_s;
  logic [31:0] dout_s, occ_s;
  int          dep;
  assign din_rdy_s  = sel ? b_din_rdy : a_din_rdy;
  assign dout_vld_s = sel ? b_dout_vld : a_dout_vld;
  assign dout_s     = sel ? {24'h0, b_dout} : a_dout;
  assign occ_s      = sel ? 32'(b_occ) : 32'(a_occ);
  assign dep        = sel ? 1 : 4;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          first_out_cyc, last_out_cyc, prev_out_cyc;
  logic        mark_first = 1'b0;
  logic        hold_vld = 1'b0;
  logic [31:0] hold_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d, depth %0d)", name, act, exp, cyc, dep);
  endtask

  task automatic timeout(input string name);
    chk_cnt++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: compares every delivered beat and the stability of a stalled output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_vld && dout_vld_s) check("dout_stable", dout_s, hold_data);
      if (dout_vld_s && dout_rdy) begin
        if (exp_q.size() == 0) begin
          chk_cnt++;
          $display("FAIL unexpected_beat: got %0h expected none (cycle %0d)", dout_s, cyc);
        end else begin
          check("dout_data", dout_s, exp_q.pop_front());
        end
        if (mark_first) begin
          first_out_cyc = cyc;
          mark_first    = 1'b0;
        end
        prev_out_cyc = last_out_cyc;
        last_out_cyc = cyc;
      end
      hold_vld  = dout_vld_s && !dout_rdy;
      hold_data = dout_s;
    end else begin
      hold_vld = 1'b0;
    end
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic send(input logic [31:0] d, output int acc, output int waits);
    din     = d;
    din_vld = 1'b1;
    waits   = 0;
    acc     = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (din_rdy_s) begin
        acc = cyc;
        exp_q.push_back(sel ? {24'h0, d[7:0]} : d);
        @(posedge clk); #1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    if (acc < 0) timeout("send");
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !dout_vld_s) break;
      @(posedge clk); #1;
    end
    check("drain_queue", exp_q.size(), 0);
    check("drain_occ", occ_s, 0);
  endtask

  task automatic wait_vld(input int acc, input string name);
    int lat;
    lat     = -1;
    din_vld = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dout_vld_s) begin
        lat = cyc - acc;
        break;
      end
    end
    check(name, lat, dep);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic sc_stream();
    int acc, w, first_acc;
    first_acc  = 0;
    dout_rdy   = 1'b1;
    mark_first = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      send(i, acc, w);
      if (i == 1) first_acc = acc;
      check("stream_no_stall", w, 0);
      if (i == 8) check("stream_occ", occ_s, dep);
    end
    drain();
    check("stream_latency", first_out_cyc - first_acc, dep);
    check("stream_rate", last_out_cyc - first_out_cyc, 15);
  endtask

  task automatic sc_fill();
    int acc, w;
    dout_rdy = 1'b0;
    for (int i = 0; i < dep; i++) begin
      send(32'hA0 + i, acc, w);
      check("fill_accept", w, 0);
    end
    din     = 32'hA0 + dep;
    din_vld = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("fill_din_rdy", din_rdy_s, 0);
      check("fill_occ", occ_s, dep);
      check("fill_dout", dout_s, 32'hA0);
      @(posedge clk); #1;
    end
    dout_rdy = 1'b1;
    for (int i = dep; i <= 5; i++) send(32'hA0 + i, acc, w);
    drain();
  endtask

  task automatic sc_bubble();
    int acc, w;
    dout_rdy = 1'b0;
    send(32'h11, acc, w);
    idle(2);
    send(32'h22, acc, w);
    idle(3);
    @(negedge clk);
    check("bubble_occ", occ_s, 2);
    check("bubble_dout", dout_s, 32'h11);
    check("bubble_vld", dout_vld_s, 1);
    @(posedge clk); #1;
    drain();
    check("bubble_back_to_back", last_out_cyc - prev_out_cyc, 1);
  endtask

  task automatic sc_pass();
    int acc, w;
    dout_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) send(i, acc, w);
    check("pass_full_occ", occ_s, 4);
    dout_rdy = 1'b1;
    send(32'h5, acc, w);
    check("pass_accept_when_full", w, 0);
    check("pass_occ_held", occ_s, 4);
    drain();
  endtask

  task automatic sc_flush();
    int acc, w;
    dout_rdy = 1'b1;
    for (int i = 1; i <= 3; i++) send(32'h30 + i, acc, w);
    din     = 32'hFF;
    din_vld = 1'b1;
    flush   = 1'b1;
    @(negedge clk);
    check("flush_din_rdy", din_rdy_s, 0);
    @(posedge clk);
    exp_q.delete();
    #1;
    flush   = 1'b0;
    din_vld = 1'b0;
    check("flush_occ", occ_s, 0);
    check("flush_vld", dout_vld_s, 0);
    send(32'h77, acc, w);
    wait_vld(acc, "flush_then_latency");
    drain();
  endtask

  task automatic sc_reset();
    int acc, w;
    dout_rdy = 1'b0;
    send(32'h41, acc, w);
    send(32'h42, acc, w);
    idle(4);
    @(negedge clk);
    check("rst_pre_vld", dout_vld_s, 1);
    check("rst_pre_occ", occ_s, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_vld", dout_vld_s, 0);
    check("rst_async_dout", dout_s, 0);
    check("rst_async_occ", occ_s, 0);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    dout_rdy = 1'b1;
    send(32'h5A, acc, w);
    wait_vld(acc, "rst_then_latency");
    drain();
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    din_vld  = 1'b0;
    dout_rdy = 1'b0;
    din      = '0;
    sel      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a_vld", a_dout_vld, 0);
    check("reset_a_dout", a_dout, 0);
    check("reset_a_occ", 32'(a_occ), 0);
    check("reset_b_vld", b_dout_vld, 0);
    check("reset_b_dout", 32'(b_dout), 0);
    check("reset_b_occ", 32'(b_occ), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sc_stream();
    sc_fill();
    sc_bubble();
    sc_pass();
    sc_flush();
    sc_reset();

    sel = 1'b1;
    sc_stream();
    sc_fill();
    sc_flush();

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
